// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit display: each grant latches the winner's
// value for HOLD_CYCLES clocks; otherwise the live default value is shown.
module display_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             default_val,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy,
    output logic [3:0]              bcd0,
    output logic [3:0]              bcd1,
    output logic [3:0]              bcd2,
    output logic [3:0]              bcd3
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES);
    localparam int unsigned PW = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [CW-1:0] LAST      = CW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      ptr;
    logic [15:0]        disp;

    logic               found;
    logic [PW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [15:0]        win_data;
    int unsigned        scan_idx;
    logic               arb_point;
    logic [15:0]        shown;

    // First set request at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found      = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_data   = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[scan_idx]) begin
                found      = 1'b1;
                win_idx    = PW'(scan_idx);
                win_onehot = NUM_REQ'(1) << scan_idx;
                win_data   = req_data[16*scan_idx +: 16];
            end
        end
    end

    assign arb_point = (state == ST_IDLE) || (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            cnt   <= '0;
            ptr   <= '0;
            disp  <= '0;
        end else if (arb_point) begin
            cnt <= '0;
            if (found) begin
                state <= ST_HOLD;
                grant <= win_onehot;
                disp  <= win_data;
                ptr   <= (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
            end else begin
                state <= ST_IDLE;
                grant <= '0;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign busy  = (state == ST_HOLD);
    assign done  = (busy && cnt == LAST) ? grant : '0;
    assign shown = busy ? disp : default_val;

    assign bcd0 = shown[3:0];
    assign bcd1 = shown[7:4];
    assign bcd2 = shown[11:8];
    assign bcd3 = shown[15:12];

endmodule
